// File: rtl/inst_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, inst}
// with early stall, redirect flush and wrong-path drop window.
module inst_queue #(
  parameter int DEPTH    = 8,
  parameter int SKID     = 2,
  parameter int DROP_CYC = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  input  logic                       inst_valid_i,
  output logic                       stall_o,
  input  logic                       flush_i,
  output logic                       dq_valid_o,
  input  logic                       dq_ready_i,
  output logic [31:0]                dq_pc_o,
  output logic [31:0]                dq_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(DROP_CYC+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [DW-1:0] drop_q;
  logic          ovf_q;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   head;

  logic full;
  logic dropping;
  logic enq;
  logic deq;
  logic lost;

  assign full     = (count_q == CW'(DEPTH));
  assign dropping = (drop_q != '0);

  assign dq_valid_o = (count_q != '0);
  assign deq = dq_valid_o & dq_ready_i & ~flush_i;
  assign enq = inst_valid_i & ~dropping
             & ~flush_i & (~full | deq);

  // valid input lost to a full queue: SKID undersized
  assign lost = inst_valid_i & ~dropping
              & ~flush_i & full & ~deq;

  assign stall_o = (count_q >= CW'(DEPTH-SKID))
                 | flush_i;

  assign head      = mem[rd_ptr];
  assign dq_pc_o   = dq_valid_o ? head[63:32] : '0;
  assign dq_inst_o = dq_valid_o ? head[31:0]  : '0;

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= {pc_i, inst_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= DW'(DROP_CYC);
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (enq & ~deq): count_q <= count_q + CW'(1);
        (deq & ~enq): count_q <= count_q - CW'(1);
        default:      count_q <= count_q;
      endcase
      if (dropping) drop_q <= drop_q - DW'(1);
      if (lost) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected pcs,
// a negedge monitor pops and compares on every dequeue.
module tb_inst_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        stall_o;
  logic        flush_i;
  logic        dq_valid_o;
  logic        dq_ready_i;
  logic [31:0] dq_pc_o;
  logic [31:0] dq_inst_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  inst_queue #(.DEPTH(8), .SKID(2), .DROP_CYC(2)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .pc_i(pc_i),
    .inst_i(inst_i),
    .inst_valid_i(inst_valid_i),
    .stall_o(stall_o),
    .flush_i(flush_i),
    .dq_valid_o(dq_valid_o),
    .dq_ready_i(dq_ready_i),
    .dq_pc_o(dq_pc_o),
    .dq_inst_o(dq_inst_o),
    .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, return #1 after the edge.
  task automatic put(logic v, logic [31:0] pc, logic rdy,
                     logic fl, logic push);
    inst_valid_i = v;
    pc_i         = pc;
    inst_i       = inst_of(pc);
    dq_ready_i   = rdy;
    flush_i      = fl;
    if (push) exp_q.push_back(pc);
    if (fl) exp_q.delete();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (reset_ni && dq_valid_o && dq_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deq: got pc %h expected none",
                 dq_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("deq_pc", dq_pc_o, e);
        chk("deq_inst", dq_inst_o, inst_of(e));
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    reset_ni     = 1'b0;
    pc_i         = '0;
    inst_i       = '0;
    inst_valid_i = 1'b0;
    dq_ready_i   = 1'b0;
    flush_i      = 1'b0;
    #12;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(dq_valid_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_pc", dq_pc_o, 0);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: three entries, no dequeue
    put(1, 32'h0, 0, 0, 1);
    chk("t1_valid_c1", 32'(dq_valid_o), 1);
    chk("t1_head_c1", dq_pc_o, 32'h0);
    put(1, 32'h4, 0, 0, 1);
    put(1, 32'h8, 0, 0, 1);
    chk("t1_count", 32'(count_o), 3);
    chk("t1_head", dq_pc_o, 32'h0);

    // 2: fill; stall at 6, two skid entries still fit
    put(1, 32'hC, 0, 0, 1);
    put(1, 32'h10, 0, 0, 1);
    chk("t2_stall5", 32'(stall_o), 0);
    put(1, 32'h14, 0, 0, 1);
    chk("t2_stall6", 32'(stall_o), 1);
    put(1, 32'h18, 0, 0, 1);
    put(1, 32'h1C, 0, 0, 1);
    chk("t2_count8", 32'(count_o), 8);
    chk("t2_ovf", 32'(overflow_o), 0);

    // 3: full with simultaneous enq/deq
    put(1, 32'h20, 1, 0, 1);
    chk("t3_count", 32'(count_o), 8);
    chk("t3_head", dq_pc_o, 32'h4);
    chk("t3_ovf", 32'(overflow_o), 0);

    // 4: full, no deq: input lost, overflow sticky
    put(1, 32'h24, 0, 0, 0);
    chk("t4_count", 32'(count_o), 8);
    chk("t4_ovf", 32'(overflow_o), 1);

    // 5: drain to 5, flush, two dropped, third kept
    put(0, 32'h0, 1, 0, 0);
    put(0, 32'h0, 1, 0, 0);
    put(0, 32'h0, 1, 0, 0);
    chk("t5_count5", 32'(count_o), 5);
    chk("t5_head5", dq_pc_o, 32'h10);
    put(1, 32'h50, 1, 1, 0);
    chk("t5_flush_cnt", 32'(count_o), 0);
    chk("t5_flush_vld", 32'(dq_valid_o), 0);
    chk("t5_flush_pc", dq_pc_o, 0);
    chk("t5_flush_stall", 32'(stall_o), 1);
    put(1, 32'h100, 0, 0, 0);
    chk("t5_drop1", 32'(count_o), 0);
    put(1, 32'h104, 0, 0, 0);
    chk("t5_drop2", 32'(count_o), 0);
    put(1, 32'h108, 0, 0, 1);
    chk("t5_keep", 32'(count_o), 1);
    chk("t5_head", dq_pc_o, 32'h108);
    chk("t5_ovf_sticky", 32'(overflow_o), 1);
    chk("t5_stall", 32'(stall_o), 0);

    // asynchronous reset mid-operation
    reset_ni = 1'b0;
    #2;
    chk("ar_count", 32'(count_o), 0);
    chk("ar_valid", 32'(dq_valid_o), 0);
    chk("ar_ovf", 32'(overflow_o), 0);
    exp_q.delete();
    inst_valid_i = 1'b0;
    dq_ready_i   = 1'b0;
    #2;
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 6: stream 20 entries with random ready
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 500) begin
      if (sent < 20 && !stall_o) begin
        put(1, 32'h1000 + 32'(4*sent),
            1'($urandom_range(0, 1)), 0, 1);
        sent++;
      end else begin
        put(0, 32'h0, 1'($urandom_range(0, 1)), 0, 0);
      end
      cyc++;
    end
    chk("t6_timeout", 32'(cyc < 500), 1);
    chk("t6_sent", 32'(sent), 20);
    put(0, 32'h0, 0, 0, 0);
    chk("t6_count", 32'(count_o), 0);
    chk("t6_left", 32'(exp_q.size()), 0);
    chk("t6_ovf", 32'(overflow_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
